// File: rtl/powlib_ipmaxi_pkg.sv
// Shared constants for the powlib bus-to-AXI master bridge: op codes, AXI
// field widths/encodings, packet offsets and the bridge state type.
package powlib_ipmaxi_pkg;

    localparam int POWLIB_BW = 8;
    localparam int OPW       = 4;

    localparam logic [OPW-1:0] OP_WRITE = 4'd0;
    localparam logic [OPW-1:0] OP_READ  = 4'd1;

    localparam int AXI_LENW   = 8;
    localparam int AXI_SIZEW  = 3;
    localparam int AXI_BURSTW = 2;
    localparam int AXI_RESPW  = 2;

    localparam logic [AXI_RESPW-1:0]  AXI_OKAY       = 2'b00;
    localparam logic [AXI_BURSTW-1:0] AXI_BURST_INCR = 2'b01;

    // Packed packet layout {op, be, data}: idx 0 = data LSB, 1 = be LSB,
    // 2 = op LSB, 3 = total packet width.
    function automatic int pack_off(input int bpd, input int idx);
        case (idx)
            0:       return 0;
            1:       return POWLIB_BW * bpd;
            2:       return POWLIB_BW * bpd + bpd;
            default: return POWLIB_BW * bpd + bpd + OPW;
        endcase
    endfunction

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RD_OUT  = 3'd5
    } state_t;

endpackage

// File: rtl/powlib_ipmaxi.sv
// powlib bus-to-AXI master bridge: one single-beat AXI write or read in
// flight at a time; read data is returned as a bus write packet.
//
// state   | meaning
// IDLE    | wrrdy=1, waiting for a bus request
// WR_REQ  | awvalid/wvalid presented, each drops after its own handshake
// WR_RESP | bready=1, waiting for the write response
// RD_REQ  | arvalid presented
// RD_DATA | rready=1, waiting for read data
// RD_OUT  | rdvld=1 with the response packet, waiting for rdrdy
module powlib_ipmaxi
    import powlib_ipmaxi_pkg::*;
#(
    parameter int               B_BPD  = 4,
    parameter int               B_AW   = POWLIB_BW * B_BPD,
    localparam int              B_DW   = POWLIB_BW * B_BPD,
    parameter int               IDW    = 1,
    parameter logic [IDW-1:0]   ID_VAL = '0,
    parameter logic [B_AW-1:0]  B_BASE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [B_AW-1:0]              wraddr,
    input  logic [B_DW+B_BPD+OPW-1:0]    wrdata,
    input  logic                         wrvld,
    output logic                         wrrdy,
    output logic [B_AW-1:0]              rdaddr,
    output logic [B_DW+B_BPD+OPW-1:0]    rddata,
    output logic                         rdvld,
    input  logic                         rdrdy,
    output logic [IDW-1:0]               awid,
    output logic [B_AW-1:0]              awaddr,
    output logic [AXI_LENW-1:0]          awlen,
    output logic [AXI_SIZEW-1:0]         awsize,
    output logic [AXI_BURSTW-1:0]        awburst,
    output logic                         awvalid,
    input  logic                         awready,
    output logic [B_DW-1:0]              wdata,
    output logic [B_BPD-1:0]             wstrb,
    output logic                         wlast,
    output logic                         wvalid,
    input  logic                         wready,
    input  logic [AXI_RESPW-1:0]         bresp,
    input  logic                         bvalid,
    output logic                         bready,
    output logic [IDW-1:0]               arid,
    output logic [B_AW-1:0]              araddr,
    output logic [AXI_LENW-1:0]          arlen,
    output logic [AXI_SIZEW-1:0]         arsize,
    output logic [AXI_BURSTW-1:0]        arburst,
    output logic                         arvalid,
    input  logic                         arready,
    input  logic [B_DW-1:0]              rdata,
    input  logic [AXI_RESPW-1:0]         rresp,
    input  logic                         rlast,
    input  logic                         rvalid,
    output logic                         rready,
    output logic [7:0]                   err_cnt
);

    localparam int OFF_0 = pack_off(B_BPD, 0);
    localparam int OFF_1 = pack_off(B_BPD, 1);
    localparam int OFF_2 = pack_off(B_BPD, 2);
    localparam int OFF_3 = pack_off(B_BPD, 3);

    state_t            state, state_nxt;
    logic [B_AW-1:0]   addr_q;
    logic [B_DW-1:0]   data_q;
    logic [B_BPD-1:0]  be_q;
    logic              awvalid_q, wvalid_q;
    logic [B_AW-1:0]   rdaddr_q;
    logic [OFF_3-1:0]  rddata_q;
    logic [7:0]        err_q;
    logic [OPW-1:0]    req_op;
    logic              accept, err_evt;

    // Single-beat transfers never look at rlast.
    logic unused_rlast;
    assign unused_rlast = rlast;

    assign req_op = wrdata[OFF_3-1:OFF_2];
    assign accept = wrvld && (state == IDLE);
    assign err_evt = (accept && (req_op != OP_WRITE) && (req_op != OP_READ))
                  || ((state == WR_RESP) && bvalid && (bresp != AXI_OKAY))
                  || ((state == RD_DATA) && rvalid && (rresp != AXI_OKAY));

    assign wrrdy   = (state == IDLE);
    assign bready  = (state == WR_RESP);
    assign arvalid = (state == RD_REQ);
    assign rready  = (state == RD_DATA);
    assign rdvld   = (state == RD_OUT);
    assign awvalid = awvalid_q;
    assign wvalid  = wvalid_q;
    assign awaddr  = addr_q;
    assign araddr  = addr_q;
    assign wdata   = data_q;
    assign wstrb   = be_q;
    assign rdaddr  = rdaddr_q;
    assign rddata  = rddata_q;
    assign err_cnt = err_q;

    assign awid    = ID_VAL;
    assign arid    = ID_VAL;
    assign awlen   = '0;
    assign arlen   = '0;
    assign awsize  = AXI_SIZEW'($clog2(B_BPD));
    assign arsize  = AXI_SIZEW'($clog2(B_BPD));
    assign awburst = AXI_BURST_INCR;
    assign arburst = AXI_BURST_INCR;
    assign wlast   = 1'b1;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode; an AW or W channel already handshaken counts as done.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && (req_op == OP_WRITE))     state_nxt = WR_REQ;
                else if (accept && (req_op == OP_READ)) state_nxt = RD_REQ;
            end
            WR_REQ:  if ((!awvalid_q || awready) && (!wvalid_q || wready)) state_nxt = WR_RESP;
            WR_RESP: if (bvalid)  state_nxt = IDLE;
            RD_REQ:  if (arready) state_nxt = RD_DATA;
            RD_DATA: if (rvalid)  state_nxt = RD_OUT;
            RD_OUT:  if (rdrdy)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request; the AXI address is rebased here so awaddr/araddr are plain flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            data_q <= '0;
            be_q   <= '0;
        end else if (accept) begin
            addr_q <= wraddr - B_BASE;
            data_q <= wrdata[OFF_1-1:OFF_0];
            be_q   <= wrdata[OFF_2-1:OFF_1];
        end
    end

    // AW and W valids rise together and fall independently on their own handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
        end else if (accept && (req_op == OP_WRITE)) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
        end else begin
            if (awready) awvalid_q <= 1'b0;
            if (wready)  wvalid_q  <= 1'b0;
        end
    end

    // Return address is taken from the read request; read data is repacked as a bus write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdaddr_q <= '0;
            rddata_q <= '0;
        end else begin
            if (accept && (req_op == OP_READ)) rdaddr_q <= wrdata[OFF_0 +: B_AW];
            if ((state == RD_DATA) && rvalid)  rddata_q <= {OP_WRITE, {B_BPD{1'b1}}, rdata};
        end
    end

    // Saturating error counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         err_q <= 8'd0;
        else if (err_evt && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end

endmodule
